// File: rtl/rs_bank.sv
// Age-ordered reservation station: a collapsing queue of renamed instructions.
// The queue snoops the CDB and issues the oldest fully-ready entry to its functional unit.
module rs_bank #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 3,
  parameter int OP_WIDTH   = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         valid_in,
  input  logic [OP_WIDTH-1:0]          opcode_in,
  input  logic [TAG_WIDTH-1:0]         rob_idx_in,
  input  logic [DATA_WIDTH-1:0]        V_i_in,
  input  logic [DATA_WIDTH-1:0]        V_j_in,
  input  logic [TAG_WIDTH-1:0]         Q_i_in,
  input  logic [TAG_WIDTH-1:0]         Q_j_in,
  input  logic                         i_ready_in,
  input  logic                         j_ready_in,
  input  logic                         cdb_valid_in,
  input  logic [TAG_WIDTH-1:0]         cdb_tag_in,
  input  logic [DATA_WIDTH-1:0]        cdb_data_in,
  input  logic                         fu_ready_in,
  input  logic                         flush_in,
  output logic [DATA_WIDTH-1:0]        rval1_out,
  output logic [DATA_WIDTH-1:0]        rval2_out,
  output logic [OP_WIDTH-1:0]          opcode_out,
  output logic [TAG_WIDTH-1:0]         rob_idx_out,
  output logic                         issue_valid_out,
  output logic                         free_out,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic                  busy;
    logic [OP_WIDTH-1:0]   op;
    logic [TAG_WIDTH-1:0]  rob;
    logic                  ri;
    logic [TAG_WIDTH-1:0]  qi;
    logic [DATA_WIDTH-1:0] vi;
    logic                  rj;
    logic [TAG_WIDTH-1:0]  qj;
    logic [DATA_WIDTH-1:0] vj;
  } entry_t;

  entry_t                r_q [DEPTH];
  logic [CW-1:0]         r_count;
  logic                  r_issue;
  logic [DATA_WIDTH-1:0] r_rval1;
  logic [DATA_WIDTH-1:0] r_rval2;
  logic [OP_WIDTH-1:0]   r_opcode;
  logic [TAG_WIDTH-1:0]  r_rob;

  entry_t                w_nxt [DEPTH];
  entry_t                w_up  [DEPTH];
  entry_t                w_new;
  entry_t                w_sel_e;
  logic [DEPTH-1:0]      w_shift;
  logic                  w_found;
  logic                  w_issue;
  logic                  w_free;
  logic                  w_disp;
  logic [CW-1:0]         w_wr_pos;

  assign w_free   = (r_count < CW'(DEPTH));
  assign w_disp   = valid_in && w_free;
  assign w_issue  = fu_ready_in && w_found;
  assign w_wr_pos = r_count - CW'(w_issue);

  // Oldest eligible slot wins; w_shift marks it and every younger slot.
  always_comb begin
    w_found = 1'b0;
    w_shift = '0;
    w_sel_e = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!w_found && r_q[k].busy && r_q[k].ri && r_q[k].rj) begin
        w_found = 1'b1;
        w_sel_e = r_q[k];
      end
      w_shift[k] = w_found;
    end
  end

  always_comb begin
    w_new      = '0;
    w_new.busy = 1'b1;
    w_new.op   = opcode_in;
    w_new.rob  = rob_idx_in;
    w_new.ri   = i_ready_in;
    w_new.qi   = Q_i_in;
    w_new.vi   = V_i_in;
    w_new.rj   = j_ready_in;
    w_new.qj   = Q_j_in;
    w_new.vj   = V_j_in;
    if (cdb_valid_in && !i_ready_in && Q_i_in == cdb_tag_in) begin
      w_new.ri = 1'b1;
      w_new.vi = cdb_data_in;
    end
    if (cdb_valid_in && !j_ready_in && Q_j_in == cdb_tag_in) begin
      w_new.rj = 1'b1;
      w_new.vj = cdb_data_in;
    end
  end

  // Collapse first, then wake the (possibly shifted) entry, then overlay the dispatch.
  always_comb begin
    w_up  = '{default: '0};
    w_nxt = '{default: '0};
    for (int unsigned k = 0; k < DEPTH - 1; k++) begin
      w_up[k] = r_q[k+1];
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_nxt[k] = (w_issue && w_shift[k]) ? w_up[k] : r_q[k];
      if (cdb_valid_in && w_nxt[k].busy && !w_nxt[k].ri && w_nxt[k].qi == cdb_tag_in) begin
        w_nxt[k].ri = 1'b1;
        w_nxt[k].vi = cdb_data_in;
      end
      if (cdb_valid_in && w_nxt[k].busy && !w_nxt[k].rj && w_nxt[k].qj == cdb_tag_in) begin
        w_nxt[k].rj = 1'b1;
        w_nxt[k].vj = cdb_data_in;
      end
      if (w_disp && CW'(k) == w_wr_pos) begin
        w_nxt[k] = w_new;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_q[k] <= '0;
      end
      r_count  <= '0;
      r_issue  <= 1'b0;
      r_rval1  <= '0;
      r_rval2  <= '0;
      r_opcode <= '0;
      r_rob    <= '0;
    end else if (flush_in) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_q[k] <= '0;
      end
      r_count <= '0;
      r_issue <= 1'b0;
    end else begin
      r_q     <= w_nxt;
      r_count <= r_count + CW'(w_disp) - CW'(w_issue);
      r_issue <= w_issue;
      if (w_issue) begin
        r_rval1  <= w_sel_e.vi;
        r_rval2  <= w_sel_e.vj;
        r_opcode <= w_sel_e.op;
        r_rob    <= w_sel_e.rob;
      end
    end
  end

  assign rval1_out       = r_rval1;
  assign rval2_out       = r_rval2;
  assign opcode_out      = r_opcode;
  assign rob_idx_out     = r_rob;
  assign issue_valid_out = r_issue;
  assign free_out        = w_free;
  assign count_out       = r_count;

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank: hand-computed expectations for dispatch, wakeup,
// bypass, back-pressure, dispatch+issue overlap, flush and asynchronous reset.
module tb_rs_bank;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic [3:0]  opcode_in;
  logic [2:0]  rob_idx_in;
  logic [31:0] V_i_in, V_j_in;
  logic [2:0]  Q_i_in, Q_j_in;
  logic        i_ready_in, j_ready_in;
  logic        cdb_valid_in;
  logic [2:0]  cdb_tag_in;
  logic [31:0] cdb_data_in;
  logic        fu_ready_in;
  logic        flush_in;
  logic [31:0] rval1_out, rval2_out;
  logic [3:0]  opcode_out;
  logic [2:0]  rob_idx_out;
  logic        issue_valid_out;
  logic        free_out;
  logic [2:0]  count_out;

  int n_vec = 0;
  int n_err = 0;

  rs_bank #(.DEPTH(4), .DATA_WIDTH(32), .TAG_WIDTH(3), .OP_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .opcode_in(opcode_in),
    .rob_idx_in(rob_idx_in), .V_i_in(V_i_in), .V_j_in(V_j_in), .Q_i_in(Q_i_in),
    .Q_j_in(Q_j_in), .i_ready_in(i_ready_in), .j_ready_in(j_ready_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .fu_ready_in(fu_ready_in), .flush_in(flush_in), .rval1_out(rval1_out),
    .rval2_out(rval2_out), .opcode_out(opcode_out), .rob_idx_out(rob_idx_out),
    .issue_valid_out(issue_valid_out), .free_out(free_out), .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic st(input string tag, input logic iv, input logic [2:0] cnt);
    chk({tag, ".iv"}, 32'(issue_valid_out), 32'(iv));
    chk({tag, ".cnt"}, 32'(count_out), 32'(cnt));
  endtask

  task automatic iss(input string tag, input logic [3:0] op, input logic [2:0] rob,
                     input logic [31:0] r1, input logic [31:0] r2);
    chk({tag, ".iv"}, 32'(issue_valid_out), 32'd1);
    chk({tag, ".op"}, 32'(opcode_out), 32'(op));
    chk({tag, ".rob"}, 32'(rob_idx_out), 32'(rob));
    chk({tag, ".r1"}, rval1_out, r1);
    chk({tag, ".r2"}, rval2_out, r2);
  endtask

  task automatic disp(input logic [3:0] op, input logic [2:0] rob,
                      input logic [31:0] vi, input logic ri, input logic [2:0] qi,
                      input logic [31:0] vj, input logic rj, input logic [2:0] qj);
    valid_in = 1'b1; opcode_in = op; rob_idx_in = rob;
    V_i_in = vi; i_ready_in = ri; Q_i_in = qi;
    V_j_in = vj; j_ready_in = rj; Q_j_in = qj;
  endtask

  task automatic cdb(input logic v, input logic [2:0] tag, input logic [31:0] data);
    cdb_valid_in = v; cdb_tag_in = tag; cdb_data_in = data;
  endtask

  initial begin
    rst_in = 1'b0; valid_in = 1'b0; opcode_in = '0; rob_idx_in = '0;
    V_i_in = '0; V_j_in = '0; Q_i_in = '0; Q_j_in = '0;
    i_ready_in = 1'b0; j_ready_in = 1'b0; fu_ready_in = 1'b0; flush_in = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);

    // Reset / idle
    #12;
    st("rst", 1'b0, 3'd0);
    chk("rst.free", 32'(free_out), 32'd1);
    chk("rst.r1", rval1_out, 32'd0);
    chk("rst.rob", 32'(rob_idx_out), 32'd0);
    rst_in = 1'b1;
    tick();
    st("idle", 1'b0, 3'd0);
    fu_ready_in = 1'b1;
    disp(4'd3, 3'd2, 32'd5, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0);
    tick();
    st("t1.disp", 1'b0, 3'd1);
    valid_in = 1'b0;
    tick();
    iss("t1.iss", 4'd3, 3'd2, 32'd5, 32'd7);
    chk("t1.cnt", 32'(count_out), 32'd0);
    tick();
    st("t1.after", 1'b0, 3'd0);
    chk("t1.hold", rval1_out, 32'd5);

    // Wakeup and age order
    fu_ready_in = 1'b0;
    disp(4'd1, 3'd1, 32'h11, 1'b1, 3'd0, 32'h0, 1'b0, 3'd5);
    tick();
    disp(4'd2, 3'd2, 32'h21, 1'b1, 3'd0, 32'h22, 1'b1, 3'd0);
    tick();
    valid_in = 1'b0;
    st("t2.two", 1'b0, 3'd2);
    fu_ready_in = 1'b1;
    tick();
    iss("t2.B", 4'd2, 3'd2, 32'h21, 32'h22);
    chk("t2.B.cnt", 32'(count_out), 32'd1);
    cdb(1'b1, 3'd5, 32'h99);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    st("t2.wake", 1'b0, 3'd1);
    tick();
    iss("t2.A", 4'd1, 3'd1, 32'h11, 32'h99);
    chk("t2.A.cnt", 32'(count_out), 32'd0);

    // Dispatch-time CDB bypass
    disp(4'd6, 3'd3, 32'hDEAD, 1'b0, 3'd4, 32'h55, 1'b1, 3'd0);
    cdb(1'b1, 3'd4, 32'h1234);
    tick();
    valid_in = 1'b0;
    cdb(1'b0, 3'd0, 32'd0);
    st("t3.disp", 1'b0, 3'd1);
    tick();
    iss("t3.iss", 4'd6, 3'd3, 32'h1234, 32'h55);
    tick();

    // Full / back-pressure
    fu_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(4'(k + 8), 3'(k), 32'h100 + 32'(k), 1'b1, 3'd0, 32'h200 + 32'(k), 1'b1, 3'd0);
      tick();
    end
    st("t4.full", 1'b0, 3'd4);
    chk("t4.free", 32'(free_out), 32'd0);
    disp(4'd15, 3'd7, 32'hBAD, 1'b1, 3'd0, 32'hBAD, 1'b1, 3'd0);
    tick();
    st("t4.drop", 1'b0, 3'd4);
    fu_ready_in = 1'b1;
    disp(4'd14, 3'd6, 32'hBAD, 1'b1, 3'd0, 32'hBAD, 1'b1, 3'd0);
    tick();
    valid_in = 1'b0;
    iss("t4.i0", 4'd8, 3'd0, 32'h100, 32'h200);
    chk("t4.i0.cnt", 32'(count_out), 32'd3);
    chk("t4.i0.free", 32'(free_out), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      iss("t4.in", 4'(k + 8), 3'(k), 32'h100 + 32'(k), 32'h200 + 32'(k));
    end
    tick();
    st("t4.empty", 1'b0, 3'd0);

    // Simultaneous dispatch + issue at count 2
    fu_ready_in = 1'b0;
    disp(4'd1, 3'd1, 32'hA1, 1'b1, 3'd0, 32'hA2, 1'b1, 3'd0);
    tick();
    disp(4'd2, 3'd2, 32'h0, 1'b0, 3'd6, 32'hB2, 1'b1, 3'd0);
    tick();
    st("t5.two", 1'b0, 3'd2);
    fu_ready_in = 1'b1;
    disp(4'd3, 3'd3, 32'hC3, 1'b1, 3'd0, 32'hC4, 1'b1, 3'd0);
    tick();
    valid_in = 1'b0;
    iss("t5.X", 4'd1, 3'd1, 32'hA1, 32'hA2);
    chk("t5.X.cnt", 32'(count_out), 32'd2);
    tick();
    iss("t5.Z", 4'd3, 3'd3, 32'hC3, 32'hC4);
    chk("t5.Z.cnt", 32'(count_out), 32'd1);
    cdb(1'b1, 3'd6, 32'h66);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    st("t5.wake", 1'b0, 3'd1);
    tick();
    iss("t5.Y", 4'd2, 3'd2, 32'h66, 32'hB2);

    // Flush with three entries and a pending issue
    fu_ready_in = 1'b0;
    disp(4'd4, 3'd1, 32'h1, 1'b1, 3'd0, 32'h2, 1'b1, 3'd0);
    tick();
    disp(4'd5, 3'd2, 32'h3, 1'b1, 3'd0, 32'h4, 1'b1, 3'd0);
    tick();
    disp(4'd6, 3'd3, 32'h5, 1'b1, 3'd0, 32'h0, 1'b0, 3'd7);
    tick();
    valid_in = 1'b0;
    st("t6.three", 1'b0, 3'd3);
    fu_ready_in = 1'b1;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    st("t6.flush", 1'b0, 3'd0);
    chk("t6.free", 32'(free_out), 32'd1);
    cdb(1'b1, 3'd7, 32'h77);
    tick();
    cdb(1'b0, 3'd0, 32'd0);
    tick();
    st("t6.nocdb", 1'b0, 3'd0);

    // Asynchronous reset with an issue strobe in flight
    disp(4'd9, 3'd4, 32'h44, 1'b1, 3'd0, 32'h45, 1'b1, 3'd0);
    tick();
    valid_in = 1'b0;
    disp(4'd9, 3'd5, 32'h46, 1'b1, 3'd0, 32'h47, 1'b1, 3'd0);
    fu_ready_in = 1'b0;
    tick();
    valid_in = 1'b0;
    fu_ready_in = 1'b1;
    tick();
    iss("t7.pre", 4'd9, 3'd4, 32'h44, 32'h45);
    #2;
    rst_in = 1'b0;
    #1;
    st("t7.arst", 1'b0, 3'd0);
    chk("t7.r1", rval1_out, 32'd0);
    #2;
    rst_in = 1'b1;
    tick();
    tick();
    st("t7.post", 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
